// File: rtl/setcc_flagunit.sv
// Registered ALU condition-flag unit: WIDTH-bit result plus C/Z/N/V flags,
// an architectural flag register, a save/restore flag stack and a branch condition evaluator.
module setcc_flagunit #(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       op,
  input  logic             in_valid,
  input  logic             flag_we,
  output logic [WIDTH:0]   result,
  output logic             out_valid,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v,
  input  logic [3:0]       cond,
  output logic             cond_true,
  input  logic             push,
  input  logic             pop,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  // Handshake: in_valid qualifies op/op1/op2/flag_we at a rising edge; out_valid is
  // high for exactly the following cycle. There is no backpressure and no stall.

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_ADC = 3'd3;
  localparam logic [2:0] OP_SBB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  localparam int         SPW     = $clog2(STACK_DEPTH) + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [WIDTH:0]   result_q;
  logic             out_valid_q;
  logic [3:0]       flags_q, flags_d;   // {c, z, n, v}
  logic [SPW-1:0]   sp_q, sp_d;
  logic             full_q, empty_q, err_q;
  logic [3:0]       stack_q [STACK_DEPTH];

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             is_logic;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   alu_res;
  logic [3:0]       alu_flags;
  logic             do_push, do_pop, err_set;
  logic [SPW-2:0]   push_idx, pop_idx;

  always_comb begin
    b_eff    = op2;
    cin      = 1'b0;
    is_logic = 1'b0;
    case (op)
      OP_ADD:         ;
      OP_SUB, OP_CMP: begin b_eff = ~op2; cin = 1'b1;       end
      OP_ADC:         cin = flags_q[3];
      OP_SBB:         begin b_eff = ~op2; cin = flags_q[3]; end
      default:        is_logic = 1'b1;
    endcase
    sum = {1'b0, op1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    case (op)
      OP_AND:  alu_res = {1'b0, op1 & op2};
      OP_OR:   alu_res = {1'b0, op1 | op2};
      OP_XOR:  alu_res = {1'b0, op1 ^ op2};
      default: alu_res = sum;
    endcase
    // Overflow: both effective operands share a sign that the result does not.
    alu_flags[3] = is_logic ? 1'b0 : alu_res[WIDTH];
    alu_flags[2] = (alu_res[WIDTH-1:0] == '0);
    alu_flags[1] = alu_res[WIDTH-1];
    alu_flags[0] = is_logic ? 1'b0 :
                   ((op1[WIDTH-1] == b_eff[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]));
  end

  // Simultaneous push and pop cancel; boundary violations only raise the sticky error.
  always_comb begin
    do_push  = push & ~pop & ~full_q;
    do_pop   = pop & ~push & ~empty_q;
    err_set  = (push & ~pop & full_q) | (pop & ~push & empty_q);
    push_idx = sp_q[SPW-2:0];
    pop_idx  = sp_q[SPW-2:0] - (SPW-1)'(1);
    sp_d     = sp_q;
    if (do_push) sp_d = sp_q + SPW'(1);
    if (do_pop)  sp_d = sp_q - SPW'(1);
    flags_d = flags_q;
    if (in_valid && flag_we) flags_d = alu_flags;
    else if (do_pop)         flags_d = stack_q[pop_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= 4'b0000;
      sp_q        <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid && (op != OP_CMP)) result_q <= alu_res;
      flags_q <= flags_d;
      sp_q    <= sp_d;
      full_q  <= (sp_d == SP_FULL);
      empty_q <= (sp_d == '0);
      err_q   <= err_q | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) stack_q[push_idx] <= flags_q;
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = flags_q[2];
      4'h1: cond_true = ~flags_q[2];
      4'h2: cond_true = flags_q[3];
      4'h3: cond_true = ~flags_q[3];
      4'h4: cond_true = flags_q[1];
      4'h5: cond_true = ~flags_q[1];
      4'h6: cond_true = flags_q[0];
      4'h7: cond_true = ~flags_q[0];
      4'h8: cond_true = flags_q[3] & ~flags_q[2];
      4'h9: cond_true = ~flags_q[3] | flags_q[2];
      4'hA: cond_true = (flags_q[1] == flags_q[0]);
      4'hB: cond_true = (flags_q[1] != flags_q[0]);
      4'hC: cond_true = ~flags_q[2] & (flags_q[1] == flags_q[0]);
      4'hD: cond_true = flags_q[2] | (flags_q[1] != flags_q[0]);
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign result      = result_q;
  assign out_valid   = out_valid_q;
  assign c           = flags_q[3];
  assign z           = flags_q[2];
  assign n           = flags_q[1];
  assign v           = flags_q[0];
  assign stack_full  = full_q;
  assign stack_empty = empty_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_setcc_flagunit.sv
// Directed bench for setcc_flagunit (WIDTH=32, STACK_DEPTH=4): scoreboard queue of
// {result, c, z, n, v} checked by a monitor on out_valid, plus direct flag/stack checks.
`timescale 1ns/1ps
module tb_setcc_flagunit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  op1, op2;
  logic [2:0]    op;
  logic          in_valid, flag_we;
  logic [W:0]    result;
  logic          out_valid, c, z, n, v;
  logic [3:0]    cond;
  logic          cond_true;
  logic          push, pop;
  logic          stack_full, stack_empty, stack_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+4:0] exp_q[$];

  setcc_flagunit #(.WIDTH(W), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .op1(op1), .op2(op2), .op(op), .in_valid(in_valid),
    .flag_we(flag_we), .result(result), .out_valid(out_valid), .c(c), .z(z), .n(n), .v(v),
    .cond(cond), .cond_true(cond_true), .push(push), .pop(pop),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pop one expected entry per out_valid cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got result 0x%0h expected no output", result);
        end else begin
          chk("result_flags", {result, c, z, n, v}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic we, input logic [W:0] er, input logic [3:0] ef);
    op = o; op1 = a; op2 = b; flag_we = we; in_valid = 1'b1;
    exp_q.push_back({er, ef});
    @(posedge clk); #1;
    in_valid = 1'b0; flag_we = 1'b0;
  endtask

  task automatic ctl(input logic pu, input logic po);
    push = pu; pop = po;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic check_conds(input string tag, input logic [15:0] exp_map);
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #0.2;
      chk($sformatf("%s_cond%0h", tag, i), {63'd0, cond_true}, {63'd0, exp_map[i]});
    end
  endtask

  initial begin
    rst = 1'b1; op1 = '0; op2 = '0; op = 3'd0; in_valid = 1'b0; flag_we = 1'b0;
    cond = 4'd0; push = 1'b0; pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_result", {31'd0, result}, 64'd0);
    chk("reset_state", {out_valid, c, z, n, v, stack_full, stack_empty, stack_err}, 64'b00000010);

    // ADD wrapping to zero
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33'h1_0000_0000, 4'b1100);
    check_conds("add", 16'h66A5);
    @(posedge clk); #1;

    // SUB signed overflow
    issue(3'd1, 32'h8000_0000, 32'h0000_0001, 1'b1, 33'h1_7FFF_FFFF, 4'b1001);
    check_conds("sub", 16'h6966);
    @(posedge clk); #1;

    // 64-bit add: ADD then ADC back to back
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33'h1_0000_0000, 4'b1100);
    issue(3'd3, 32'h0, 32'h0, 1'b1, 33'h0_0000_0001, 4'b0000);

    // CMP leaves result alone; AND without flag_we leaves flags alone
    issue(3'd0, 32'h20, 32'h0A, 1'b1, 33'h0_0000_002A, 4'b0000);
    issue(3'd2, 32'h5, 32'h5, 1'b1, 33'h0_0000_002A, 4'b1100);
    issue(3'd5, 32'hF0F0, 32'h0F0F, 1'b0, 33'h0, 4'b1100);
    issue(3'd6, 32'h8000_0000, 32'h1, 1'b1, 33'h0_8000_0001, 4'b0010);
    issue(3'd7, 32'h5, 32'h5, 1'b1, 33'h0, 4'b0100);
    issue(3'd4, 32'hA, 32'h3, 1'b1, 33'h1_0000_0006, 4'b1000);

    // flags to 1010, fill the stack
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFE, 4'b1010);
    check_conds("cn", 16'h6996);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("push%0d_full_before", i), {63'd0, stack_full}, 64'd0);
      ctl(1'b1, 1'b0);
    end
    chk("full_after4", {stack_full, stack_empty, stack_err}, 64'b100);
    ctl(1'b1, 1'b0);
    chk("push_overflow", {stack_full, stack_empty, stack_err}, 64'b101);

    issue(3'd7, 32'h0, 32'h0, 1'b1, 33'h0, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      ctl(1'b0, 1'b1);
      chk($sformatf("pop%0d_flags", i), {c, z, n, v}, 64'b1010);
      chk($sformatf("pop%0d_empty", i), {63'd0, stack_empty}, (i == 3) ? 64'd1 : 64'd0);
    end
    ctl(1'b0, 1'b1);
    chk("pop_underflow", {c, z, n, v, stack_full, stack_empty, stack_err}, 64'b1010011);

    // push+pop cancel, then pop racing an ALU flag update
    ctl(1'b1, 1'b0);
    chk("repush_empty", {63'd0, stack_empty}, 64'd0);
    ctl(1'b1, 1'b1);
    chk("pushpop_cancel", {c, z, n, v, stack_full, stack_empty}, 64'b101000);
    pop = 1'b1;
    issue(3'd7, 32'h5, 32'h5, 1'b1, 33'h0, 4'b0100);
    pop = 1'b0;
    chk("pop_vs_alu", {c, z, n, v, stack_empty}, 64'b01001);

    // reset mid-sequence with push and an op pending
    ctl(1'b1, 1'b0);
    rst = 1'b1; push = 1'b1; in_valid = 1'b1; flag_we = 1'b1;
    op = 3'd0; op1 = 32'h7; op2 = 32'h9;
    @(posedge clk); #1;
    rst = 1'b0; push = 1'b0; in_valid = 1'b0; flag_we = 1'b0;
    chk("rst2_result", {31'd0, result}, 64'd0);
    chk("rst2_state", {out_valid, c, z, n, v, stack_full, stack_empty, stack_err}, 64'b00000010);

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
